obstacle_columns_unit: RTL and testbench

Parametrised obstacle engine for the Flappy playfield. It generalises the fixed two-building unit to NUM_COLS independently scrolling columns. Each column has a random gap and a per-column hit/destroy state machine. Stage progression raises scroll speed. The block sits between the frame-timing logic and the pixel mixer, and returns per-column draw and destroy flags to the collision logic.

---
 rtl/obstacle_pkg.sv | 25 ++
 rtl/obstacle_column.sv | 147 ++++++++++++++
 rtl/obstacle_columns_unit.sv | 151 +++++++++++++++
 tb/tb_obstacle_columns_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle column engine.
//   col_state_t : per-column hit/destroy state
//   COLOR_*     : 12-bit {R,G,B} nibble colours used by the pixel mux
//   LFSR_*      : seed and Fibonacci tap mask (taps 16/14/13/11)
package obstacle_pkg;

  typedef enum logic [1:0] {
    COL_ACTIVE = 2'd0,
    COL_HIT    = 2'd1,
    COL_GONE   = 2'd2
  } col_state_t;

  localparam logic [11:0] COLOR_ACTIVE = 12'h2A2;
  localparam logic [11:0] COLOR_HIT    = 12'hF40;
  localparam logic [11:0] COLOR_NONE   = 12'h000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bits 15, 13, 12, 10 correspond to taps 16, 14, 13, 11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obstacle_column.sv
// One scrolling obstacle column: position, gap, hit FSM, blink timer and pixel test.
//   clk, resetN     : clock, asynchronous active-high reset
//   start_of_frame  : frame pulse; moves the column by step
//   step            : pixels to move this frame
//   lfsr_raw        : random bits used for the gap on respawn
//   pxl_x, pxl_y    : pixel under test
//   collision       : bird overlaps this column
//   draw            : pixel lies on the (visible) column, combinational
//   draw_hit        : column is in the hit state (selects hit colour)
//   destructed      : column has been hit since its last respawn
//   passed          : pulse, column respawned while still active
module obstacle_column
  import obstacle_pkg::*;
#(
  parameter int unsigned INDEX      = 0,
  parameter int unsigned NUM_COLS   = 2,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned COL_W      = 64,
  parameter int unsigned GAP_H      = 160,
  parameter int unsigned MARGIN     = 32,
  parameter int unsigned SPACING    = 320,
  parameter int unsigned HIT_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start_of_frame,
  input  logic [3:0]  step,
  input  logic [8:0]  lfsr_raw,
  input  logic [10:0] pxl_x,
  input  logic [10:0] pxl_y,
  input  logic        collision,
  output logic        draw,
  output logic        draw_hit,
  output logic        destructed,
  output logic        passed
);

  localparam int unsigned GAP_RANGE = SCREEN_H - GAP_H - 2 * MARGIN;

  // x is 12-bit signed, so SCREEN_W + NUM_COLS*SPACING must stay below 2048.
  localparam logic signed [11:0] X_INIT   = 12'(SCREEN_W + INDEX * SPACING);
  localparam logic        [11:0] X_WRAP   = 12'(NUM_COLS * SPACING);
  localparam logic        [10:0] GAP_INIT = 11'(MARGIN + 64 * INDEX);
  localparam logic signed [12:0] COL_W_S  = 13'(COL_W);

  col_state_t              state_q, state_d;
  logic signed [11:0]      x_q, x_d;
  logic        [10:0]      gap_q, gap_d;
  logic        [7:0]       timer_q, timer_d;

  logic signed [12:0]      x_ext;
  logic signed [12:0]      x_moved;
  logic signed [12:0]      right_edge;
  logic                    respawn;
  logic        [10:0]      raw_ext;
  logic        [10:0]      gap_rand;
  logic signed [12:0]      px;
  logic                    in_x;
  logic                    in_y;

  assign x_ext      = {x_q[11], x_q};
  assign x_moved    = x_ext - $signed({9'b0, step});
  assign right_edge = x_moved + COL_W_S;
  assign respawn    = start_of_frame && (right_edge <= 13'sd0);

  // Fold the 9-bit random value into [0, GAP_RANGE).
  assign raw_ext  = {2'b00, lfsr_raw};
  assign gap_rand = (raw_ext < 11'(GAP_RANGE)) ? raw_ext : raw_ext - 11'(GAP_RANGE);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    gap_d   = gap_q;
    timer_d = timer_q;

    if (start_of_frame) begin
      x_d = x_moved[11:0];
    end

    if (respawn) begin
      // Respawn takes priority over any collision in the same cycle.
      x_d     = x_moved[11:0] + X_WRAP;
      gap_d   = 11'(MARGIN) + gap_rand;
      state_d = COL_ACTIVE;
      timer_d = 8'd0;
    end else begin
      unique case (state_q)
        COL_ACTIVE: begin
          if (collision) begin
            state_d = COL_HIT;
            timer_d = 8'(HIT_FRAMES);
          end
        end
        COL_HIT: begin
          if (start_of_frame) begin
            if (timer_q <= 8'd1) begin
              state_d = COL_GONE;
              timer_d = 8'd0;
            end else begin
              timer_d = timer_q - 8'd1;
            end
          end
        end
        COL_GONE: begin
          state_d = COL_GONE;
        end
        default: begin
          state_d = COL_ACTIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q <= COL_ACTIVE;
      x_q     <= X_INIT;
      gap_q   <= GAP_INIT;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      gap_q   <= gap_d;
      timer_q <= timer_d;
    end
  end

  assign px   = $signed({2'b00, pxl_x});
  assign in_x = (px >= x_ext) && (px < x_ext + COL_W_S);
  assign in_y = ({1'b0, pxl_y} < {1'b0, gap_q}) ||
                ({1'b0, pxl_y} >= ({1'b0, gap_q} + 12'(GAP_H)));

  always_comb begin
    draw = 1'b0;
    unique case (state_q)
      COL_ACTIVE: draw = in_x && in_y;
      COL_HIT:    draw = in_x && in_y && !timer_q[2];  // blink
      default:    draw = 1'b0;
    endcase
  end

  assign draw_hit   = (state_q == COL_HIT);
  assign destructed = (state_q != COL_ACTIVE);
  assign passed     = respawn && (state_q == COL_ACTIVE);

endmodule

// File: rtl/obstacle_columns_unit.sv
// Obstacle engine: NUM_COLS scrolling columns with random gaps and stage-driven speed.
//   clk, resetN                  : clock, asynchronous active-high reset
//   start_of_frame               : one-cycle pulse per video frame
//   slow_down                    : slow-motion request, sampled at start_of_frame
//   pxl_x, pxl_y                 : current pixel
//   collision[NUM_COLS]          : bird overlaps column i
//   drawing[NUM_COLS]            : pixel lies on column i (registered)
//   destructed[NUM_COLS]         : column i hit since its last respawn
//   Red/Green/Blue_level         : colour of lowest-index drawing column (registered)
//   stage, speed, slow_draw      : progression state and slow mode of the current frame
module obstacle_columns_unit
  import obstacle_pkg::*;
#(
  parameter int unsigned NUM_COLS     = 2,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned COL_W        = 64,
  parameter int unsigned GAP_H        = 160,
  parameter int unsigned MARGIN       = 32,
  parameter int unsigned SPACING      = 320,
  parameter int unsigned BASE_SPEED   = 2,
  parameter int unsigned MAX_SPEED    = 8,
  parameter int unsigned STAGE_PASSES = 4,
  parameter int unsigned HIT_FRAMES   = 30
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                start_of_frame,
  input  logic                slow_down,
  input  logic [10:0]         pxl_x,
  input  logic [10:0]         pxl_y,
  input  logic [NUM_COLS-1:0] collision,
  output logic [NUM_COLS-1:0] drawing,
  output logic [NUM_COLS-1:0] destructed,
  output logic [3:0]          Red_level,
  output logic [3:0]          Green_level,
  output logic [3:0]          Blue_level,
  output logic [7:0]          stage,
  output logic [3:0]          speed,
  output logic                slow_draw
);

  logic [15:0]         lfsr_q;
  logic [3:0]          speed_q, speed_d;
  logic [7:0]          stage_q, stage_d;
  logic [7:0]          pass_cnt_q, pass_cnt_d;
  logic                slow_q, slow_d;
  logic [NUM_COLS-1:0] drawing_q;
  logic [11:0]         rgb_q, rgb_d;

  logic [3:0]          half_speed;
  logic [3:0]          step;
  logic [NUM_COLS-1:0] col_draw;
  logic [NUM_COLS-1:0] col_hit;
  logic [NUM_COLS-1:0] col_passed;
  logic [3:0]          n_passed;
  logic [8:0]          pass_sum;

  assign half_speed = speed_q >> 1;
  assign step = slow_down ? ((half_speed == 4'd0) ? 4'd1 : half_speed) : speed_q;

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
    obstacle_column #(
      .INDEX      (i),
      .NUM_COLS   (NUM_COLS),
      .SCREEN_W   (SCREEN_W),
      .SCREEN_H   (SCREEN_H),
      .COL_W      (COL_W),
      .GAP_H      (GAP_H),
      .MARGIN     (MARGIN),
      .SPACING    (SPACING),
      .HIT_FRAMES (HIT_FRAMES)
    ) u_col (
      .clk            (clk),
      .resetN         (resetN),
      .start_of_frame (start_of_frame),
      .step           (step),
      .lfsr_raw       (lfsr_q[8:0]),
      .pxl_x          (pxl_x),
      .pxl_y          (pxl_y),
      .collision      (collision[i]),
      .draw           (col_draw[i]),
      .draw_hit       (col_hit[i]),
      .destructed     (destructed[i]),
      .passed         (col_passed[i])
    );
  end

  // Several columns may pass in one frame; each one counts.
  always_comb begin
    n_passed = 4'd0;
    for (int i = 0; i < int'(NUM_COLS); i++) begin
      n_passed = n_passed + 4'(col_passed[i]);
    end
  end

  assign pass_sum = {1'b0, pass_cnt_q} + {5'b0, n_passed};

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    stage_d    = stage_q;
    speed_d    = speed_q;
    slow_d     = slow_q;
    if (start_of_frame) begin
      slow_d     = slow_down;
      pass_cnt_d = pass_sum[7:0];
      if (pass_sum >= 9'(STAGE_PASSES)) begin
        pass_cnt_d = 8'(pass_sum - 9'(STAGE_PASSES));
        if (stage_q != 8'hFF) stage_d = stage_q + 8'd1;
        if (speed_q < 4'(MAX_SPEED)) speed_d = speed_q + 4'd1;
      end
    end
  end

  // Iterate downwards so the lowest drawing index wins.
  always_comb begin
    rgb_d = COLOR_NONE;
    for (int i = int'(NUM_COLS) - 1; i >= 0; i--) begin
      if (col_draw[i]) rgb_d = col_hit[i] ? COLOR_HIT : COLOR_ACTIVE;
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      lfsr_q     <= LFSR_SEED;
      speed_q    <= 4'(BASE_SPEED);
      stage_q    <= 8'd0;
      pass_cnt_q <= 8'd0;
      slow_q     <= 1'b0;
      drawing_q  <= '0;
      rgb_q      <= COLOR_NONE;
    end else begin
      lfsr_q     <= lfsr_next(lfsr_q);
      speed_q    <= speed_d;
      stage_q    <= stage_d;
      pass_cnt_q <= pass_cnt_d;
      slow_q     <= slow_d;
      drawing_q  <= col_draw;
      rgb_q      <= rgb_d;
    end
  end

  assign drawing     = drawing_q;
  assign Red_level   = rgb_q[11:8];
  assign Green_level = rgb_q[7:4];
  assign Blue_level  = rgb_q[3:0];
  assign stage       = stage_q;
  assign speed       = speed_q;
  assign slow_draw   = slow_q;

endmodule

// File: tb/tb_obstacle_columns_unit.sv
// Directed bench for obstacle_columns_unit (defaults) plus a tightly spaced
// second instance used to put two columns on the same pixel.
module tb_obstacle_columns_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start_of_frame;
  logic        slow_down;
  logic [10:0] pxl_x, pxl_y;
  logic [1:0]  collision, collision2;
  logic [1:0]  drawing, destructed, drawing2, destructed2;
  logic [3:0]  red, green, blue, red2, green2, blue2;
  logic [7:0]  stage, stage2;
  logic [3:0]  speed, speed2;
  logic        slow_draw, slow_draw2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  obstacle_columns_unit dut (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (start_of_frame),
    .slow_down      (slow_down),
    .pxl_x          (pxl_x),
    .pxl_y          (pxl_y),
    .collision      (collision),
    .drawing        (drawing),
    .destructed     (destructed),
    .Red_level      (red),
    .Green_level    (green),
    .Blue_level     (blue),
    .stage          (stage),
    .speed          (speed),
    .slow_draw      (slow_draw)
  );

  obstacle_columns_unit #(.SPACING(32)) dut2 (
    .clk            (clk),
    .resetN         (resetN),
    .start_of_frame (start_of_frame),
    .slow_down      (slow_down),
    .pxl_x          (pxl_x),
    .pxl_y          (pxl_y),
    .collision      (collision2),
    .drawing        (drawing2),
    .destructed     (destructed2),
    .Red_level      (red2),
    .Green_level    (green2),
    .Blue_level     (blue2),
    .stage          (stage2),
    .speed          (speed2),
    .slow_draw      (slow_draw2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: SOF pulse (optionally with collision) then two idle cycles.
  task automatic frame(input logic [1:0] coll);
    start_of_frame = 1'b1;
    collision      = coll;
    tick();
    start_of_frame = 1'b0;
    collision      = 2'b00;
    tick();
    tick();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame(2'b00);
  endtask

  function automatic int x0();
    return int'(dut.g_col[0].u_col.x_q);
  endfunction

  function automatic int x1();
    return int'(dut.g_col[1].u_col.x_q);
  endfunction

  initial begin
    int g;
    int guard;
    int prev;
    int delta;

    resetN = 1'b1;
    start_of_frame = 1'b0;
    slow_down = 1'b0;
    pxl_x = 11'd0;
    pxl_y = 11'd0;
    collision = 2'b00;
    collision2 = 2'b00;
    repeat (3) tick();

    check("rst_drawing", drawing, 0);
    check("rst_destructed", destructed, 0);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_stage", stage, 0);
    check("rst_speed", speed, 2);
    check("rst_slow_draw", slow_draw, 0);
    check("rst_x0", x0(), 640);
    check("rst_x1", x1(), 960);
    check("rst_gap0", dut.g_col[0].u_col.gap_q, 32);
    check("rst_gap1", dut.g_col[1].u_col.gap_q, 96);

    resetN = 1'b0;
    tick();
    tick();
    check("no_move_before_sof", x0(), 640);

    frames(10);
    check("x0_10f", x0(), 620);
    check("x1_10f", x1(), 940);
    check("stage_10f", stage, 0);

    pxl_x = 11'd630; pxl_y = 11'd0;
    tick(); tick();
    check("draw_above_gap", drawing, 2'b01);
    check("rgb_active", {red, green, blue}, 12'h2A2);
    pxl_y = 11'd100;
    tick(); tick();
    check("draw_in_gap", drawing, 2'b00);
    check("rgb_none", {red, green, blue}, 12'h000);

    // Column 0 passes the left edge after 342 frames at step 2.
    frames(341);
    check("x0_before_respawn", x0(), -62);
    frame(2'b00);
    check("x0_respawn", x0(), 576);
    check("x1_at_respawn0", x1(), 256);
    check("pass_cnt_1", dut.pass_cnt_q, 1);
    g = int'(dut.g_col[0].u_col.gap_q);
    check("gap0_range", (g >= 32 && g <= 287), 1);

    frames(160);
    check("x1_respawn", x1(), 576);
    check("pass_cnt_2", dut.pass_cnt_q, 2);
    frames(320);
    check("stage_1", stage, 1);
    check("speed_3", speed, 3);
    check("pass_cnt_wrap", dut.pass_cnt_q, 0);
    check("x0_stage1", x0(), 256);
    check("x1_stage1", x1(), 576);

    // Hit on column 0.
    pxl_x = 11'd280; pxl_y = 11'd0;
    tick(); tick();
    check("pre_hit_draw", drawing, 2'b01);
    collision = 2'b01;
    tick();
    collision = 2'b00;
    check("destructed_next_cycle", destructed, 2'b01);
    tick();
    check("hit_blink_off", drawing, 2'b00);
    frames(3);
    check("x0_hit3", x0(), 247);
    check("hit_blink_on", drawing, 2'b01);
    check("rgb_hit", {red, green, blue}, 12'hF40);
    frames(30);
    check("x0_hit33", x0(), 157);
    check("gone_destructed", destructed, 2'b01);
    pxl_x = 11'd167;
    tick(); tick();
    check("gone_no_draw", drawing, 2'b00);
    frames(74);
    check("x0_gone_respawn", x0(), 575);
    check("gone_respawn_clears", destructed, 2'b00);
    check("gone_not_counted", dut.pass_cnt_q, 0);
    check("stage_still_1", stage, 1);

    // Collision on column 1 in the same cycle as its respawn.
    frames(106);
    check("x1_before_respawn", x1(), -63);
    frame(2'b10);
    check("x1_respawn_coll", x1(), 574);
    check("x0_at_coll", x0(), 254);
    check("respawn_beats_coll", destructed, 2'b00);
    check("pass_cnt_coll", dut.pass_cnt_q, 1);

    // Slow motion at speed 3.
    slow_down = 1'b1;
    frame(2'b00);
    check("slow_step_1", x0(), 253);
    check("slow_draw_on", slow_draw, 1);
    slow_down = 1'b0;
    frame(2'b00);
    check("normal_step_3", x0(), 250);
    check("slow_draw_off", slow_draw, 0);

    // Run until the speed ceiling.
    guard = 0;
    while (speed != 4'd8 && guard < 5000) begin
      frame(2'b00);
      guard++;
    end
    check("speed_reaches_8", speed, 8);
    check("stage_at_speed8", stage, 6);
    slow_down = 1'b1;
    prev = x0();
    frame(2'b00);
    delta = prev - x0();
    if (delta < 0) delta += 640;
    check("slow_step_4", delta, 4);
    check("slow_draw_8", slow_draw, 1);
    slow_down = 1'b0;
    frames(1000);
    check("speed_saturated", speed, 8);
    check("stage_kept_rising", stage > 8'd6, 1);

    // Mid-frame reset.
    pxl_x = 11'd0; pxl_y = 11'd0;
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("midrst_drawing", drawing, 0);
    check("midrst_destructed", destructed, 0);
    check("midrst_rgb", {red, green, blue}, 0);
    check("midrst_stage", stage, 0);
    check("midrst_speed", speed, 2);
    check("midrst_x0", x0(), 640);
    tick();
    resetN = 1'b0;
    tick();

    // Overlapping columns in the second instance: x0=640, x1=672.
    pxl_x = 11'd690; pxl_y = 11'd0;
    tick(); tick();
    check("overlap_drawing", drawing2, 2'b11);
    check("overlap_rgb_active", {red2, green2, blue2}, 12'h2A2);
    collision2 = 2'b01;
    tick();
    collision2 = 2'b00;
    frames(3);
    check("overlap_drawing_hit", drawing2, 2'b11);
    check("overlap_priority_col0", {red2, green2, blue2}, 12'hF40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
